// File: rtl/adc_share_arbiter.sv
// Round-robin sharing of one start/done ADC among NUM_REQ requesters.
// Optional conversion timeout: define ADC_SHARE_ARBITER_TIMEOUT_EN.
module adc_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int TMO_WIDTH  = 16
) (
  input  logic                  Clk_i,
  input  logic                  Reset_n_i,
  input  logic [NUM_REQ-1:0]    Req_i,
  output logic [NUM_REQ-1:0]    Grant_o,
  output logic [NUM_REQ-1:0]    Done_o,
  output logic [DATA_WIDTH-1:0] Value_o,
  output logic                  Busy_o,
  output logic                  AdcStart_o,
  input  logic                  AdcDone_i,
  input  logic [DATA_WIDTH-1:0] AdcValue_i,
  input  logic [TMO_WIDTH-1:0]  TimeoutPreset_i,
  output logic                  Timeout_o
);

  localparam int LW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_REL
  } state_t;

  state_t                r_state;
  logic [LW-1:0]         r_last;
  logic [NUM_REQ-1:0]    r_grant;
  logic [NUM_REQ-1:0]    r_done;
  logic [DATA_WIDTH-1:0] r_value;
  logic                  r_busy;
  logic                  r_start;

  logic [LW-1:0]         w_sel;
  logic [NUM_REQ-1:0]    w_onehot;
  int                    w_idx;

`ifdef ADC_SHARE_ARBITER_TIMEOUT_EN
  logic [TMO_WIDTH-1:0]  r_tmo;
  logic                  r_timeout;
  assign Timeout_o = r_timeout;
`else
  logic                  w_unused_tmo;
  assign w_unused_tmo = ^TimeoutPreset_i;
  assign Timeout_o = 1'b0;
`endif

  // Walk downward so the nearest requester after r_last wins.
  always_comb begin
    w_sel = r_last;
    w_idx = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_idx = (int'(r_last) + i) % NUM_REQ;
      if (Req_i[w_idx]) w_sel = LW'(w_idx);
    end
  end

  assign w_onehot = NUM_REQ'(1) << w_sel;

  always_ff @(posedge Clk_i) begin
    if (!Reset_n_i) begin
      r_state <= S_IDLE;
      r_last  <= LW'(NUM_REQ - 1);
      r_grant <= '0;
      r_done  <= '0;
      r_value <= '0;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
`ifdef ADC_SHARE_ARBITER_TIMEOUT_EN
      r_tmo     <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_done <= '0;
`ifdef ADC_SHARE_ARBITER_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (|Req_i) begin
            r_grant <= w_onehot;
            r_last  <= w_sel;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_CONV;
`ifdef ADC_SHARE_ARBITER_TIMEOUT_EN
            r_tmo   <= TimeoutPreset_i;
`endif
          end
        end
        S_CONV: begin
          if (AdcDone_i) begin
            r_value <= AdcValue_i;
            r_done  <= r_grant;
            r_grant <= '0;
            r_start <= 1'b0;
            r_state <= S_REL;
          end
`ifdef ADC_SHARE_ARBITER_TIMEOUT_EN
          else if (r_tmo == TMO_WIDTH'(1)) begin
            r_timeout <= 1'b1;
            r_done    <= r_grant;
            r_grant   <= '0;
            r_start   <= 1'b0;
            r_state   <= S_REL;
          end else if (r_tmo != '0) begin
            r_tmo <= r_tmo - TMO_WIDTH'(1);
          end
`endif
        end
        // Hold off until done drops so a stale level cannot finish the next job.
        S_REL: begin
          if (!AdcDone_i) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Grant_o    = r_grant;
  assign Done_o     = r_done;
  assign Value_o    = r_value;
  assign Busy_o     = r_busy;
  assign AdcStart_o = r_start;

endmodule
